cpu_dma_burst_sm: RTL and testbench

- Parametrised bus-master sequencer for the SCSI DMA path.
- Arbitrates for the 68030 bus (BREQ/BGRANT/BGACK), then runs up to BURST_LEN longword transfers per bus tenure between the DMA FIFO and memory.
- Handles dynamic bus sizing (32-bit and 16-bit DSACK ports), single-word flush of a partial FIFO, and abort on bus error or DSACK timeout.
- Sits between the FIFO/pointer logic and the CPU bus interface.

---
 rtl/cpu_sm_pkg.sv | 44 ++++
 rtl/cpu_sm_timeout.sv | 35 +++
 rtl/cpu_dma_burst_sm.sv | 245 ++++++++++++++++++++++++
 tb/tb_cpu_dma_burst_sm.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_sm_pkg
//  Description : Shared types and constants for the CPU-side DMA sequencers:
//                FSM state encoding, DSACK responses and transfer direction.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_sm_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_REQ     = 4'd1,
        S_OWN     = 4'd2,
        S_AS      = 4'd3,
        S_DS      = 4'd4,
        S_TERM    = 4'd5,
        S_HALF2   = 4'd6,
        S_RELEASE = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    // DSACK[1:0] = {DSACK1, DSACK0}, active high
    localparam logic [1:0] ACK32    = 2'b11;
    localparam logic [1:0] ACK16    = 2'b10;
    // DSACK0 alone is an 8-bit response; no byte ports exist on this path,
    // so it completes the cycle like a full 32-bit acknowledge.
    localparam logic [1:0] ACK_D0   = 2'b01;

    localparam logic DIR_WRITE = 1'b1;  // SCSI -> memory, FIFO drains
    localparam logic DIR_READ  = 1'b0;  // memory -> SCSI, FIFO fills

    // Conditions under which a bus tenure is worth requesting
    function automatic logic start_cond(input logic dir,
                                        input logic full,
                                        input logic empty,
                                        input logic flush);
        if (dir == DIR_WRITE)
            return full | (flush & ~empty);
        else
            return empty & ~flush;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sm_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sm_timeout
//  Description : Loadable saturating down-counter with an expiry flag.
//                Load the number of cycles minus one; o_expired is set while
//                the count sits at zero.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sm_timeout #(
    parameter int WIDTH = 7
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_dma_burst_sm.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_dma_burst_sm
//  Description : 68030 bus-master sequencer for the SCSI DMA path. Arbitrates
//                for the bus, runs up to BURST_LEN longword beats per tenure
//                with 16-bit dynamic sizing, word flush, and abort on BERR or
//                DSACK timeout. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_dma_burst_sm
    import cpu_sm_pkg::*;
#(
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 5
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       i_DMAENA,
    input  logic       i_DMADIR,
    input  logic       i_FIFOFULL,
    input  logic       i_FIFOEMPTY,
    input  logic       i_FLUSHFIFO,
    input  logic       i_LASTWORD,
    input  logic       i_A1,
    input  logic       i_BGRANT,
    input  logic       i_CYCLEDONE,
    input  logic [1:0] i_DSACK,
    input  logic       i_BERR,
    output logic       o_BREQ,
    output logic       o_BGACK,
    output logic       o_PAS,
    output logic       o_PDS,
    output logic       o_SIZE1,
    output logic       o_BRIDGEOUT,
    output logic       o_BRIDGEIN,
    output logic       o_F2CPUH,
    output logic       o_F2CPUL,
    output logic       o_PLHW,
    output logic       o_PLLW,
    output logic       o_INCFIFO,
    output logic       o_DECFIFO,
    output logic       o_INCNI,
    output logic       o_INCNO,
    output logic       o_STOPFLUSH,
    output logic       o_ABORT,
    output logic       o_BUSY
);

    // The timeout count must reach TIMEOUT_CYC-1, which the default CNT_W
    // cannot hold, so the timeout counter gets its own (never narrower) width.
    localparam int TO_W = (CNT_W > $clog2(TIMEOUT_CYC)) ? CNT_W : $clog2(TIMEOUT_CYC);

    state_t r_state, w_state_nxt;

    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] w_beats_inc;
    logic             r_second;      // running the low-word half of a split beat
    logic             r_word_flush;  // current beat is a single-word flush
    logic             w_to_expired;
    logic             w_start;
    logic             w_flush_word;
    logic             w_boundary;
    logic             w_write;

    logic w_second_nxt, w_word_flush_nxt;
    logic w_breq_nxt, w_bgack_nxt, w_pas_nxt, w_pds_nxt, w_size1_nxt;
    logic w_bout_nxt, w_bin_nxt, w_f2h_nxt, w_f2l_nxt;
    logic w_plw_nxt, w_incf_nxt, w_decf_nxt, w_incni_nxt, w_incno_nxt;
    logic w_stop_nxt, w_abort_nxt, w_busy_nxt;

    logic r_breq, r_bgack, r_pas, r_pds, r_size1, r_bout, r_bin, r_f2h, r_f2l;
    logic r_plw, r_incf, r_decf, r_incni, r_incno, r_stop, r_abort, r_busy;

    assign w_write      = (i_DMADIR == DIR_WRITE);
    assign w_start      = start_cond(i_DMADIR, i_FIFOFULL, i_FIFOEMPTY, i_FLUSHFIFO);
    assign w_flush_word = i_LASTWORD & i_FLUSHFIFO & w_write;
    assign w_boundary   = w_write ? i_FIFOEMPTY : i_FIFOFULL;
    assign w_beats_inc  = (r_beats == '1) ? r_beats : r_beats + 1'b1;

    cpu_sm_timeout #(
        .WIDTH      (TO_W)
    ) u_timeout (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .i_load     (r_state == S_AS),
        .i_load_val (TO_W'(TIMEOUT_CYC - 1)),
        .i_en       (r_state == S_DS),
        .o_expired  (w_to_expired)
    );

    // Next-state decode plus the values every registered output takes in it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_DMAENA && w_start) w_state_nxt = S_REQ;
            S_REQ:     if (!i_DMAENA)                    w_state_nxt = S_IDLE;
                       else if (i_BGRANT && i_CYCLEDONE) w_state_nxt = S_OWN;
            S_OWN:     w_state_nxt = S_AS;
            S_AS:      w_state_nxt = S_DS;
            S_DS: begin
                if (i_BERR)
                    w_state_nxt = S_ERR;
                else if ((i_DSACK == ACK32) || (i_DSACK == ACK_D0))
                    w_state_nxt = S_TERM;
                else if (i_DSACK == ACK16)
                    w_state_nxt = r_size1 ? S_TERM : S_HALF2;
                else if (w_to_expired)
                    w_state_nxt = S_ERR;
            end
            S_HALF2:   w_state_nxt = S_AS;
            S_TERM: begin
                if ((w_beats_inc == CNT_W'(BURST_LEN)) || w_boundary ||
                    !i_DMAENA || r_word_flush)
                    w_state_nxt = S_RELEASE;
                else
                    w_state_nxt = S_AS;
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            S_ERR:     if (!i_DMAENA) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        // Split-beat and flush bookkeeping
        w_second_nxt     = r_second;
        w_word_flush_nxt = r_word_flush;
        if (w_state_nxt == S_HALF2)
            w_second_nxt = 1'b1;
        else if (w_state_nxt inside {S_IDLE, S_OWN, S_TERM, S_ERR})
            w_second_nxt = 1'b0;
        if (w_state_nxt == S_OWN)
            w_word_flush_nxt = 1'b0;
        else if ((w_state_nxt == S_AS) && !r_second)
            w_word_flush_nxt = w_flush_word;

        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_breq_nxt  = (w_state_nxt == S_REQ);
        w_bgack_nxt = (w_state_nxt inside {S_OWN, S_AS, S_DS, S_HALF2, S_TERM});
        w_pas_nxt   = (w_state_nxt inside {S_AS, S_DS});
        w_pds_nxt   = (w_state_nxt == S_DS);
        w_bout_nxt  = w_write & w_pas_nxt;
        w_bin_nxt   = ~w_write & w_pds_nxt;

        // Size and word steering are chosen at address time and held in DS;
        // the low-word half is always a word transfer on the low lane
        w_size1_nxt = 1'b0;
        w_f2h_nxt   = 1'b0;
        w_f2l_nxt   = 1'b0;
        if (w_state_nxt == S_AS) begin
            w_size1_nxt = r_second | w_flush_word;
            w_f2h_nxt   = w_write & ~r_second & ~i_A1;
            w_f2l_nxt   = w_write & (r_second | i_A1);
        end else if (w_state_nxt == S_DS) begin
            w_size1_nxt = r_size1;
            w_f2h_nxt   = r_f2h;
            w_f2l_nxt   = r_f2l;
        end

        w_plw_nxt   = (w_state_nxt == S_TERM) & ~w_write;
        w_incf_nxt  = (w_state_nxt == S_TERM) & ~w_write;
        w_decf_nxt  = (w_state_nxt == S_TERM) & w_write;
        w_stop_nxt  = (w_state_nxt == S_TERM) & r_word_flush;
        w_incni_nxt = (w_state_nxt == S_HALF2) & ~w_write;
        w_incno_nxt = (w_state_nxt == S_HALF2) & w_write;
        w_abort_nxt = (w_state_nxt == S_ERR) & (r_state != S_ERR);
    end

    // State, flags and registered outputs; reset drops every strobe at once
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= S_IDLE;
            r_second     <= 1'b0;
            r_word_flush <= 1'b0;
            r_breq       <= 1'b0;
            r_bgack      <= 1'b0;
            r_pas        <= 1'b0;
            r_pds        <= 1'b0;
            r_size1      <= 1'b0;
            r_bout       <= 1'b0;
            r_bin        <= 1'b0;
            r_f2h        <= 1'b0;
            r_f2l        <= 1'b0;
            r_plw        <= 1'b0;
            r_incf       <= 1'b0;
            r_decf       <= 1'b0;
            r_incni      <= 1'b0;
            r_incno      <= 1'b0;
            r_stop       <= 1'b0;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_second     <= w_second_nxt;
            r_word_flush <= w_word_flush_nxt;
            r_breq       <= w_breq_nxt;
            r_bgack      <= w_bgack_nxt;
            r_pas        <= w_pas_nxt;
            r_pds        <= w_pds_nxt;
            r_size1      <= w_size1_nxt;
            r_bout       <= w_bout_nxt;
            r_bin        <= w_bin_nxt;
            r_f2h        <= w_f2h_nxt;
            r_f2l        <= w_f2l_nxt;
            r_plw        <= w_plw_nxt;
            r_incf       <= w_incf_nxt;
            r_decf       <= w_decf_nxt;
            r_incni      <= w_incni_nxt;
            r_incno      <= w_incno_nxt;
            r_stop       <= w_stop_nxt;
            r_abort      <= w_abort_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Beats completed in this tenure: cleared on taking the bus, saturating
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            r_beats <= '0;
        else if (w_state_nxt == S_OWN)
            r_beats <= '0;
        else if (r_state == S_TERM)
            r_beats <= w_beats_inc;
    end

    assign o_BREQ      = r_breq;
    assign o_BGACK     = r_bgack;
    assign o_PAS       = r_pas;
    assign o_PDS       = r_pds;
    assign o_SIZE1     = r_size1;
    assign o_BRIDGEOUT = r_bout;
    assign o_BRIDGEIN  = r_bin;
    assign o_F2CPUH    = r_f2h;
    assign o_F2CPUL    = r_f2l;
    assign o_PLHW      = r_plw;
    assign o_PLLW      = r_plw;
    assign o_INCFIFO   = r_incf;
    assign o_DECFIFO   = r_decf;
    assign o_INCNI     = r_incni;
    assign o_INCNO     = r_incno;
    assign o_STOPFLUSH = r_stop;
    assign o_ABORT     = r_abort;
    assign o_BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_burst_sm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_dma_burst_sm
//  Description : Directed self-checking bench for cpu_dma_burst_sm.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_dma_burst_sm;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b1;
    logic       DMAENA = 0, DMADIR = 0, FIFOFULL = 0, FIFOEMPTY = 0;
    logic       FLUSHFIFO = 0, LASTWORD = 0, A1 = 0, BGRANT = 0, CYCLEDONE = 1;
    logic [1:0] DSACK = 2'b00;
    logic       BERR = 0;

    logic BREQ, BGACK, PAS, PDS, SIZE1, BOUT, BIN, F2H, F2L;
    logic PLHW, PLLW, INCF, DECF, INCNI, INCNO, STOP, ABORT, BUSY;

    cpu_dma_burst_sm dut (
        .CLK(CLK), .nRESET(nRESET), .i_DMAENA(DMAENA), .i_DMADIR(DMADIR),
        .i_FIFOFULL(FIFOFULL), .i_FIFOEMPTY(FIFOEMPTY), .i_FLUSHFIFO(FLUSHFIFO),
        .i_LASTWORD(LASTWORD), .i_A1(A1), .i_BGRANT(BGRANT), .i_CYCLEDONE(CYCLEDONE),
        .i_DSACK(DSACK), .i_BERR(BERR),
        .o_BREQ(BREQ), .o_BGACK(BGACK), .o_PAS(PAS), .o_PDS(PDS), .o_SIZE1(SIZE1),
        .o_BRIDGEOUT(BOUT), .o_BRIDGEIN(BIN), .o_F2CPUH(F2H), .o_F2CPUL(F2L),
        .o_PLHW(PLHW), .o_PLLW(PLLW), .o_INCFIFO(INCF), .o_DECFIFO(DECF),
        .o_INCNI(INCNI), .o_INCNO(INCNO), .o_STOPFLUSH(STOP), .o_ABORT(ABORT),
        .o_BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    wire [17:0] w_out = {BREQ, BGACK, PAS, PDS, SIZE1, BOUT, BIN, F2H, F2L,
                         PLHW, PLLW, INCF, DECF, INCNI, INCNO, STOP, ABORT, BUSY};
    localparam int I_BREQ = 17, I_BGACK = 16, I_PDS = 14, I_SIZE1 = 13;
    localparam int I_BOUT = 12, I_BIN = 11, I_F2H = 10, I_F2L = 9, I_PLLW = 7;
    localparam int I_INCF = 6, I_DECF = 5, I_INCNI = 4, I_INCNO = 3;
    localparam int I_STOP = 2, I_ABORT = 1;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt [0:17];
    int base [0:17];
    int n_as = 0, base_as = 0;
    int n_bgrise = 0, base_bgrise = 0;
    logic prev_pas = 1'b0, prev_bgack = 1'b0;

    initial for (int i = 0; i < 18; i++) cnt[i] = 0;

    // Cycle counts of every output and rising edges of PAS/BGACK
    always @(negedge CLK) begin
        for (int i = 0; i < 18; i++)
            if (w_out[i]) cnt[i] <= cnt[i] + 1;
        if (PAS && !prev_pas)     n_as <= n_as + 1;
        if (BGACK && !prev_bgack) n_bgrise <= n_bgrise + 1;
        prev_pas   <= PAS;
        prev_bgack <= BGACK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 18; i++) base[i] = cnt[i];
        base_as     = n_as;
        base_bgrise = n_bgrise;
    endtask

    function automatic int d(input int idx);
        return cnt[idx] - base[idx];
    endfunction

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!BUSY) begin
                ok = 1'b1;
                DMAENA = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_inputs(input logic dir, input logic full, input logic empty,
                              input logic flush, input logic lw, input logic a1,
                              input logic [1:0] ack);
        DMADIR = dir; FIFOFULL = full; FIFOEMPTY = empty; FLUSHFIFO = flush;
        LASTWORD = lw; A1 = a1; DSACK = ack; BERR = 1'b0; BGRANT = 1'b1;
    endtask

    task automatic test_reset();
        #2 nRESET = 1'b0;
        tick(); tick();
        n_cmp++;
        if (w_out !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", w_out, 18'h0);
        end
        nRESET = 1'b1;
        tick();
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_no_start();
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        DMAENA = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_start: busy got %b expected 0", BUSY);
        end
        // start condition present but grant withheld, then DMA disabled
        BGRANT = 1'b0; FIFOFULL = 1'b1;
        tick();
        n_cmp++;
        if (BREQ !== 1'b1) begin
            n_fail++;
            $display("FAIL req_asserted: breq got %b expected 1", BREQ);
        end
        DMAENA = 1'b0;
        tick();
        n_cmp++;
        if ({BREQ, BUSY} !== 2'b00) begin
            n_fail++;
            $display("FAIL req_cancel: breq/busy got %b expected 00", {BREQ, BUSY});
        end
        FIFOFULL = 1'b0;
    endtask

    task automatic test_write_burst32();
        bit ok;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        BGRANT = 1'b0;
        snap();
        DMAENA = 1'b1;
        tick(); tick(); tick();
        BGRANT = 1'b1;
        wait_idle(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL wr32_idle: busy got %b expected 0", BUSY); end
        n_cmp++;
        if (d(I_BREQ) != 3) begin n_fail++; $display("FAIL wr32_breq_cycles: got %0d expected 3", d(I_BREQ)); end
        n_cmp++;
        if (n_as - base_as != 4) begin n_fail++; $display("FAIL wr32_as_beats: got %0d expected 4", n_as - base_as); end
        n_cmp++;
        if (d(I_DECF) != 4) begin n_fail++; $display("FAIL wr32_decfifo: got %0d expected 4", d(I_DECF)); end
        n_cmp++;
        if (d(I_BGACK) != 13 || n_bgrise - base_bgrise != 1) begin
            n_fail++;
            $display("FAIL wr32_bgack: cycles %0d rises %0d expected 13 and 1", d(I_BGACK), n_bgrise - base_bgrise);
        end
        n_cmp++;
        if (d(I_BOUT) != 8 || d(I_F2H) != 8 || d(I_F2L) != 0) begin
            n_fail++;
            $display("FAIL wr32_steering: bout %0d f2h %0d f2l %0d expected 8 8 0", d(I_BOUT), d(I_F2H), d(I_F2L));
        end
        FIFOFULL = 1'b0;
    endtask

    task automatic test_read16();
        bit ok;
        set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        snap();
        DMAENA = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (INCF) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rd16_first_incfifo: got %b expected 1", INCF); end
        tick();
        FIFOFULL = 1'b1; FIFOEMPTY = 1'b0;
        wait_idle(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rd16_idle: busy got %b expected 0", BUSY); end
        n_cmp++;
        if (d(I_INCF) != 2 || d(I_PLLW) != 2) begin
            n_fail++;
            $display("FAIL rd16_incfifo: incfifo %0d pllw %0d expected 2 2", d(I_INCF), d(I_PLLW));
        end
        n_cmp++;
        if (d(I_INCNI) != 2 || d(I_INCNO) != 0) begin
            n_fail++;
            $display("FAIL rd16_incni: incni %0d incno %0d expected 2 0", d(I_INCNI), d(I_INCNO));
        end
        n_cmp++;
        if (n_as - base_as != 4 || d(I_BIN) != 4 || d(I_SIZE1) != 4) begin
            n_fail++;
            $display("FAIL rd16_halves: as %0d bridgein %0d size1 %0d expected 4 4 4", n_as - base_as, d(I_BIN), d(I_SIZE1));
        end
        FIFOFULL = 1'b0;
    endtask

    task automatic test_flush_word();
        bit ok;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        snap();
        DMAENA = 1'b1;
        wait_idle(50, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL flush_idle: busy got %b expected 0", BUSY); end
        n_cmp++;
        if (n_as - base_as != 1 || d(I_SIZE1) != 2) begin
            n_fail++;
            $display("FAIL flush_single_word: as %0d size1 %0d expected 1 2", n_as - base_as, d(I_SIZE1));
        end
        n_cmp++;
        if (d(I_DECF) != 1 || d(I_STOP) != 1 || d(I_INCNO) != 0) begin
            n_fail++;
            $display("FAIL flush_pulses: decfifo %0d stopflush %0d incno %0d expected 1 1 0", d(I_DECF), d(I_STOP), d(I_INCNO));
        end
        n_cmp++;
        if (d(I_F2L) != 2 || d(I_F2H) != 0) begin
            n_fail++;
            $display("FAIL flush_lane: f2l %0d f2h %0d expected 2 0", d(I_F2L), d(I_F2H));
        end
        FLUSHFIFO = 1'b0; LASTWORD = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        snap();
        DMAENA = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ABORT) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL timeout_abort: got %b expected 1", ABORT); end
        n_cmp++;
        if (d(I_PDS) != 64) begin n_fail++; $display("FAIL timeout_ds_cycles: got %0d expected 64", d(I_PDS)); end
        n_cmp++;
        if ({PAS, PDS, BGACK, BUSY} !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_strobes: pas/pds/bgack/busy got %b expected 0001", {PAS, PDS, BGACK, BUSY});
        end
        tick(); tick(); tick(); tick(); tick();
        n_cmp++;
        if ({ABORT, BUSY, BGACK} !== 3'b010 || d(I_ABORT) != 1) begin
            n_fail++;
            $display("FAIL timeout_hold_err: abort/busy/bgack got %b pulses %0d expected 010 1", {ABORT, BUSY, BGACK}, d(I_ABORT));
        end
        DMAENA = 1'b0;
        tick();
        n_cmp++;
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL timeout_exit: busy got %b expected 0", BUSY); end
        FIFOFULL = 1'b0;
    endtask

    task automatic test_berr();
        bit ok;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        snap();
        DMAENA = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (DECF) break;
        end
        BERR = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ABORT) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL berr_abort: got %b expected 1", ABORT); end
        tick(); tick();
        n_cmp++;
        if (d(I_DECF) != 1 || n_as - base_as != 2) begin
            n_fail++;
            $display("FAIL berr_decfifo: decfifo %0d as %0d expected 1 2", d(I_DECF), n_as - base_as);
        end
        BERR = 1'b0; DMAENA = 1'b0;
        tick();
        n_cmp++;
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL berr_exit: busy got %b expected 0", BUSY); end
        FIFOFULL = 1'b0;
    endtask

    task automatic test_reset_mid_ds();
        int seen;
        bit ok;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        DMAENA = 1'b1;
        seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (DECF) seen++;
            if (seen >= 2 && PDS) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rst_reach_beat3_ds: pds got %b expected 1", PDS); end
        nRESET = 1'b0;
        DMAENA = 1'b0;
        #1;
        n_cmp++;
        if (w_out !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_mid_ds_outputs: got %h expected %h", w_out, 18'h0);
        end
        #3 nRESET = 1'b1;
        tick(); tick();
        n_cmp++;
        if (w_out !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_release_idle: got %h expected %h", w_out, 18'h0);
        end
        FIFOFULL = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_write_burst32();
        test_read16();
        test_flush_word();
        test_timeout();
        test_berr();
        test_reset_mid_ds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
